// File: rtl/param_updown_counter_if.sv
// Control and status bundle for param_updown_counter.
// The master drives the controls and the slave (the counter) returns count, evt and cmp_hit.
interface param_updown_counter_if #(
  parameter int WIDTH = 8
);
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic             up_dn;
  logic [WIDTH-1:0] mod_max;
  logic             sat_mode;
  logic [WIDTH-1:0] cmp_val;
  logic [WIDTH-1:0] count;
  logic             evt;
  logic             cmp_hit;

  modport master (
    output clr, load, load_val, en, up_dn, mod_max, sat_mode, cmp_val,
    input  count, evt, cmp_hit
  );

  modport slave (
    input  clr, load, load_val, en, up_dn, mod_max, sat_mode, cmp_val,
    output count, evt, cmp_hit
  );
endinterface

// File: rtl/param_updown_counter.sv
// Up/down counter with a modulus set at runtime, wrap or saturate at the limit, a limit-event pulse
// and a compare flag. Priority on each edge is clear, then load, then count step.
module param_updown_counter #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  param_updown_counter_if.slave   bus
);

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_CLEAR,
    OP_LOAD,
    OP_UP,
    OP_DOWN
  } op_e;

  op_e              op;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             evt_q;
  logic             evt_d;
  logic [WIDTH-1:0] load_clamped;

  // Loads above the current modulus are clamped so count never leaves the legal range.
  assign load_clamped = (bus.load_val > bus.mod_max) ? bus.mod_max : bus.load_val;

  always_comb begin
    if (bus.clr)       op = OP_CLEAR;
    else if (bus.load) op = OP_LOAD;
    else if (bus.en)   op = bus.up_dn ? OP_UP : OP_DOWN;
    else               op = OP_HOLD;
  end

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    count_d = count_q;
    evt_d   = 1'b0;
    unique case (op)
      OP_CLEAR: count_d = RST_VAL;
      OP_LOAD:  count_d = load_clamped;
      OP_UP: begin
        // ">=" also catches a count left above a modulus that was lowered at runtime.
        if (count_q >= bus.mod_max) begin
          count_d = bus.sat_mode ? bus.mod_max : '0;
          evt_d   = 1'b1;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end
      OP_DOWN: begin
        if (count_q == '0) begin
          count_d = bus.sat_mode ? '0 : bus.mod_max;
          evt_d   = 1'b1;
        end else if (count_q > bus.mod_max) begin
          count_d = bus.mod_max;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
      default: count_d = count_q;
    endcase
  end

  // NOTE: non-blocking assignments for all registered state so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= RST_VAL;
      evt_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      evt_q   <= evt_d;
    end
  end

  assign bus.count   = count_q;
  assign bus.evt     = evt_q;
  assign bus.cmp_hit = (count_q == bus.cmp_val);

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed-vector bench for param_updown_counter (WIDTH=8, RST_VAL=0).
module tb_param_updown_counter;

  localparam int WIDTH = 8;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  param_updown_counter_if #(.WIDTH(WIDTH)) bus ();

  param_updown_counter #(.WIDTH(WIDTH), .RST_VAL('0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_state(input string tag, input int c, input int e);
    check({tag, "_count"}, 32'(bus.count), c);
    check({tag, "_evt"}, 32'(bus.evt), e);
  endtask

  task automatic do_load(input int v);
    bus.load     = 1'b1;
    bus.load_val = 8'(v);
    bus.en       = 1'b0;
    tick();
    bus.load     = 1'b0;
  endtask

  int t2_count [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
  int t2_evt   [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
  int t3_count [4]  = '{1, 0, 0, 0};
  int t3_evt   [4]  = '{0, 0, 1, 1};

  initial begin
    checks       = 0;
    errors       = 0;
    reset        = 1'b1;
    bus.clr      = 1'b0;
    bus.load     = 1'b0;
    bus.load_val = '0;
    bus.en       = 1'b0;
    bus.up_dn    = 1'b1;
    bus.mod_max  = 8'd9;
    bus.sat_mode = 1'b0;
    bus.cmp_val  = 8'd200;
    #1;
    expect_state("por", 0, 0);
    tick();
    tick();
    reset  = 1'b0;
    bus.en = 1'b1;

    // T1: first step right after release, then async reset mid-count
    tick();
    expect_state("t1_first", 1, 0);
    repeat (4) tick();
    expect_state("t1_five", 5, 0);
    reset = 1'b1;
    #1;
    expect_state("t1_async", 0, 0);
    tick();
    expect_state("t1_held", 0, 0);
    reset = 1'b0;
    tick();
    expect_state("t1_release", 1, 0);
    bus.clr = 1'b1;
    tick();
    expect_state("t1_clr_over_en", 0, 0);
    bus.clr = 1'b0;

    // T2: wrap up through mod_max=9
    for (int i = 0; i < 12; i++) begin
      tick();
      expect_state($sformatf("t2_%0d", i), t2_count[i], t2_evt[i]);
    end

    // T3: saturate going down from 2
    bus.sat_mode = 1'b1;
    bus.up_dn    = 1'b0;
    do_load(2);
    expect_state("t3_load", 2, 0);
    bus.en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_state($sformatf("t3_%0d", i), t3_count[i], t3_evt[i]);
    end
    bus.en = 1'b0;
    tick();
    expect_state("t3_idle", 0, 0);

    // T4: load clamps and beats en; clr beats load
    bus.sat_mode = 1'b0;
    bus.up_dn    = 1'b1;
    bus.load     = 1'b1;
    bus.load_val = 8'd200;
    bus.en       = 1'b1;
    tick();
    expect_state("t4_clamp", 9, 0);
    bus.clr = 1'b1;
    tick();
    expect_state("t4_clr_over_load", 0, 0);
    bus.clr  = 1'b0;
    bus.load = 1'b0;

    // T5: mod_max lowered below the count
    do_load(7);
    expect_state("t5_load_up", 7, 0);
    bus.mod_max = 8'd4;
    bus.en      = 1'b1;
    tick();
    expect_state("t5_up", 0, 1);
    bus.mod_max = 8'd9;
    do_load(7);
    expect_state("t5_load_dn", 7, 0);
    bus.mod_max = 8'd4;
    bus.up_dn   = 1'b0;
    bus.en      = 1'b1;
    tick();
    expect_state("t5_dn", 4, 0);
    tick();
    expect_state("t5_dn_next", 3, 0);

    // T6: compare flag, then the top of the 8-bit range
    bus.mod_max = 8'd9;
    bus.up_dn   = 1'b1;
    bus.cmp_val = 8'd3;
    do_load(1);
    check("t6_hit_1", 32'(bus.cmp_hit), 0);
    bus.en = 1'b1;
    tick();
    check("t6_hit_2", 32'(bus.cmp_hit), 0);
    tick();
    check("t6_hit_3", 32'(bus.cmp_hit), 1);
    bus.en = 1'b0;
    tick();
    check("t6_hit_3_idle", 32'(bus.cmp_hit), 1);
    bus.en = 1'b1;
    tick();
    check("t6_hit_4", 32'(bus.cmp_hit), 0);
    bus.cmp_val = 8'd4;
    #1;
    check("t6_hit_comb", 32'(bus.cmp_hit), 1);

    bus.mod_max = 8'd255;
    do_load(254);
    expect_state("t6_load254", 254, 0);
    bus.en = 1'b1;
    tick();
    expect_state("t6_255", 255, 0);
    tick();
    expect_state("t6_wrap0", 0, 1);
    bus.sat_mode = 1'b1;
    do_load(255);
    bus.en = 1'b1;
    tick();
    expect_state("t6_sat255", 255, 1);

    // mod_max=0: stuck at 0 with evt every enabled cycle
    bus.mod_max = 8'd0;
    bus.sat_mode = 1'b0;
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    tick();
    expect_state("m0_up_wrap", 0, 1);
    bus.up_dn = 1'b0;
    tick();
    expect_state("m0_dn_wrap", 0, 1);
    bus.sat_mode = 1'b1;
    tick();
    expect_state("m0_dn_sat", 0, 1);
    bus.en = 1'b0;
    tick();
    expect_state("m0_idle", 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
